ca_code_phase_search: RTL and testbench

- Receive-side counterpart of the GPS L1 C/A code generator.
- Takes hard-decision 1-bit samples at one sample per chip and runs a serial code-phase search against a locally generated C/A code for a selected PRN (1..32).
- Each dwell correlates over one full code period (1023 chips). On a miss, the local code is slipped by one chip. On detection, it reports lock and code phase; after all phases without detection, it reports failure.
- Sits between the front-end sign quantiser and the tracking loop, which it seeds with code phase.

---
 rtl/ca_pkg.sv | 41 ++++
 rtl/ca_code_gen.sv | 43 ++++
 rtl/ca_code_phase_search.sv | 187 ++++++++++++++++++
 tb/tb_ca_code_phase_search.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/ca_pkg.sv
// Shared constants, search-state encoding and the PRN-to-G2-tap table
// for the C/A code-phase searcher.
package ca_pkg;

  localparam int         CODE_LEN = 1023;
  localparam logic [9:0] G1_INIT  = 10'h3FF;
  localparam logic [9:0] G2_INIT  = 10'h3FF;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DWELL,
    S_EVAL,
    S_SLIP,
    S_LOCK_OUT,
    S_FAIL_OUT
  } state_e;

  // Returns {t2,t1}, the two G2 stages summed for this PRN; 0 marks an invalid PRN.
  function automatic logic [7:0] ca_taps(input logic [5:0] prn);
    case (prn)
      6'd1:  ca_taps = 8'h62;  6'd2:  ca_taps = 8'h73;
      6'd3:  ca_taps = 8'h84;  6'd4:  ca_taps = 8'h95;
      6'd5:  ca_taps = 8'h91;  6'd6:  ca_taps = 8'hA2;
      6'd7:  ca_taps = 8'h81;  6'd8:  ca_taps = 8'h92;
      6'd9:  ca_taps = 8'hA3;  6'd10: ca_taps = 8'h32;
      6'd11: ca_taps = 8'h43;  6'd12: ca_taps = 8'h65;
      6'd13: ca_taps = 8'h76;  6'd14: ca_taps = 8'h87;
      6'd15: ca_taps = 8'h98;  6'd16: ca_taps = 8'hA9;
      6'd17: ca_taps = 8'h41;  6'd18: ca_taps = 8'h52;
      6'd19: ca_taps = 8'h63;  6'd20: ca_taps = 8'h74;
      6'd21: ca_taps = 8'h85;  6'd22: ca_taps = 8'h96;
      6'd23: ca_taps = 8'h31;  6'd24: ca_taps = 8'h64;
      6'd25: ca_taps = 8'h75;  6'd26: ca_taps = 8'h86;
      6'd27: ca_taps = 8'h97;  6'd28: ca_taps = 8'hA8;
      6'd29: ca_taps = 8'h61;  6'd30: ca_taps = 8'h72;
      6'd31: ca_taps = 8'h83;  6'd32: ca_taps = 8'h94;
      default: ca_taps = 8'h00;
    endcase
  endfunction

endpackage

// File: rtl/ca_code_gen.sv
// Local C/A code generator: G1/G2 10-stage LFSRs, chip taken from the
// current state, advanced one chip per adv.
module ca_code_gen
  import ca_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic       adv,
  input  logic [7:0] taps,
  output logic       chip
);

  logic [10:1] g1_q, g1_d, g2_q, g2_d;
  logic [15:0] g2_x;

  // Stage n of G2 sits at bit n, so a 4-bit tap number indexes it directly.
  assign g2_x = {5'd0, g2_q, 1'b0};
  assign chip = g1_q[10] ^ g2_x[taps[3:0]] ^ g2_x[taps[7:4]];

  always_comb begin
    g1_d = g1_q;
    g2_d = g2_q;
    if (load) begin
      g1_d = G1_INIT;
      g2_d = G2_INIT;
    end else if (adv) begin
      g1_d = {g1_q[9:1], g1_q[3] ^ g1_q[10]};
      g2_d = {g2_q[9:1], g2_q[2] ^ g2_q[3] ^ g2_q[6] ^ g2_q[8] ^ g2_q[9] ^ g2_q[10]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      g1_q <= G1_INIT;
      g2_q <= G2_INIT;
    end else begin
      g1_q <= g1_d;
      g2_q <= g2_d;
    end
  end

endmodule

// File: rtl/ca_code_phase_search.sv
// Serial C/A code-phase search: one full-period dwell per phase, one-chip
// slip between dwells, reports lock phase or best-seen phase on exhaustion.
module ca_code_phase_search
  import ca_pkg::*;
#(
  parameter int THRESH     = 512,
  parameter int ACC_W      = 12,
  parameter int NUM_PHASES = 1023
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [5:0]       prn,
  input  logic             in_valid,
  input  logic             in_sample,
  output logic             busy,
  output logic             done,
  output logic             lock,
  output logic             fail,
  output logic [9:0]       code_phase,
  output logic [ACC_W-1:0] corr_peak
);

  localparam logic [ACC_W-1:0] ONE        = ACC_W'(1);
  localparam logic [ACC_W-1:0] ACC_MAX    = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] ACC_MIN    = ~ACC_MAX + ONE;
  localparam logic [ACC_W-1:0] THR        = ACC_W'(THRESH);
  localparam logic [9:0]       LAST_CHIP  = 10'(CODE_LEN - 1);
  localparam logic [9:0]       LAST_PHASE = 10'(NUM_PHASES - 1);

  state_e           state_q, state_d;
  logic [7:0]       taps_q, taps_d, new_taps;
  logic [ACC_W-1:0] acc_q, acc_d, acc_step, mag;
  logic [ACC_W-1:0] best_mag_q, best_mag_d, corr_peak_q, corr_peak_d;
  logic [9:0]       chip_cnt_q, chip_cnt_d, phase_q, phase_d;
  logic [9:0]       best_phase_q, best_phase_d, code_phase_q, code_phase_d;
  logic             lock_q, lock_d, fail_q, fail_d;
  logic             chip, prn_ok, hit, better, last_phase, gen_load, gen_adv;

  assign new_taps = ca_taps(prn);
  assign prn_ok   = (new_taps != 8'h00);
  assign gen_load = start && prn_ok;
  assign gen_adv  = (state_q == S_DWELL) && in_valid && !start;

  ca_code_gen u_gen (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (gen_load),
    .adv   (gen_adv),
    .taps  (taps_q),
    .chip  (chip)
  );

  assign mag        = acc_q[ACC_W-1] ? (~acc_q + ONE) : acc_q;
  assign hit        = (mag >= THR);
  assign better     = (mag > best_mag_q);
  assign last_phase = (phase_q == LAST_PHASE);

  always_comb begin
    if (in_sample == chip) acc_step = (acc_q == ACC_MAX) ? acc_q : acc_q + ONE;
    else                   acc_step = (acc_q == ACC_MIN) ? acc_q : acc_q - ONE;
  end

  // ---- FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // ---- FSM: next state; a sample arriving on a missed EVAL is the slip sample
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_DWELL:    if (in_valid && chip_cnt_q == LAST_CHIP) state_d = S_EVAL;
      S_EVAL: begin
        if (hit)             state_d = S_LOCK_OUT;
        else if (last_phase) state_d = S_FAIL_OUT;
        else if (in_valid)   state_d = S_DWELL;
        else                 state_d = S_SLIP;
      end
      S_SLIP:     if (in_valid) state_d = S_DWELL;
      S_LOCK_OUT: state_d = S_IDLE;
      S_FAIL_OUT: state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
    if (start) state_d = prn_ok ? S_DWELL : S_FAIL_OUT;
  end

  // ---- FSM: outputs
  always_comb begin
    busy = (state_q != S_IDLE);
    done = (state_q == S_LOCK_OUT) || (state_q == S_FAIL_OUT);
  end

  // ---- datapath next state
  always_comb begin
    taps_d       = taps_q;
    acc_d        = acc_q;
    chip_cnt_d   = chip_cnt_q;
    phase_d      = phase_q;
    best_mag_d   = best_mag_q;
    best_phase_d = best_phase_q;
    lock_d       = lock_q;
    fail_d       = fail_q;
    code_phase_d = code_phase_q;
    corr_peak_d  = corr_peak_q;
    case (state_q)
      S_DWELL: if (in_valid) begin
        acc_d      = acc_step;
        chip_cnt_d = chip_cnt_q + 10'd1;
      end
      S_EVAL: begin
        if (hit) begin
          lock_d       = 1'b1;
          code_phase_d = phase_q;
          corr_peak_d  = mag;
        end else begin
          if (better) begin
            best_mag_d   = mag;
            best_phase_d = phase_q;
          end
          if (last_phase) begin
            fail_d       = 1'b1;
            code_phase_d = better ? phase_q : best_phase_q;
            corr_peak_d  = better ? mag : best_mag_q;
          end else if (in_valid) begin
            phase_d    = phase_q + 10'd1;
            acc_d      = '0;
            chip_cnt_d = '0;
          end
        end
      end
      S_SLIP: if (in_valid) begin
        phase_d    = phase_q + 10'd1;
        acc_d      = '0;
        chip_cnt_d = '0;
      end
      default: ;
    endcase
    if (start) begin
      taps_d       = new_taps;
      acc_d        = '0;
      chip_cnt_d   = '0;
      phase_d      = '0;
      best_mag_d   = '0;
      best_phase_d = '0;
      lock_d       = 1'b0;
      fail_d       = !prn_ok;
      if (!prn_ok) begin
        code_phase_d = '0;
        corr_peak_d  = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      taps_q       <= '0;
      acc_q        <= '0;
      chip_cnt_q   <= '0;
      phase_q      <= '0;
      best_mag_q   <= '0;
      best_phase_q <= '0;
      lock_q       <= 1'b0;
      fail_q       <= 1'b0;
      code_phase_q <= '0;
      corr_peak_q  <= '0;
    end else begin
      taps_q       <= taps_d;
      acc_q        <= acc_d;
      chip_cnt_q   <= chip_cnt_d;
      phase_q      <= phase_d;
      best_mag_q   <= best_mag_d;
      best_phase_q <= best_phase_d;
      lock_q       <= lock_d;
      fail_q       <= fail_d;
      code_phase_q <= code_phase_d;
      corr_peak_q  <= corr_peak_d;
    end
  end

  assign lock       = lock_q;
  assign fail       = fail_q;
  assign code_phase = code_phase_q;
  assign corr_peak  = corr_peak_q;

endmodule

// File: tb/tb_ca_code_phase_search.sv
// Scoreboard bench: each search's expected result is computed from a sample-level
// correlation model and checked by an independent monitor on every done pulse.
module tb_ca_code_phase_search;

  localparam int NP     = 6;
  localparam int TH     = 512;
  localparam int AW     = 12;
  localparam int L      = 1023;
  localparam int BUDGET = (NP + 1) * 1024 * 4 + 64;

  logic          clk = 1'b0, rst_n = 1'b0, start = 1'b0, in_valid = 1'b0, in_sample = 1'b0;
  logic [5:0]    prn = '0;
  logic          busy, done, lock, fail;
  logic [9:0]    code_phase;
  logic [AW-1:0] corr_peak;

  typedef struct { int lk; int fl; int ph; int pk; } exp_t;
  exp_t sbq[$];
  exp_t me;
  int   total = 0, bad = 0, ndone = 0;
  time  t_done = 0;
  bit   sig[];
  bit   code[L];
  int   T1[33] = '{0, 2,3,4,5,1,2,1,2,3,2,3,5,6,7,8,9,1,2,3,4,5,6,1,4,5,6,7,8,1,2,3,4};
  int   T2[33] = '{0, 6,7,8,9,9,10,8,9,10,3,4,6,7,8,9,10,4,5,6,7,8,9,3,6,7,8,9,10,6,7,8,9};

  ca_code_phase_search #(.THRESH(TH), .ACC_W(AW), .NUM_PHASES(NP)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .prn        (prn),
    .in_valid   (in_valid),
    .in_sample  (in_sample),
    .busy       (busy),
    .done       (done),
    .lock       (lock),
    .fail       (fail),
    .code_phase (code_phase),
    .corr_peak  (corr_peak)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Full 1023-chip Gold code for PRN p, straight from the two LFSR definitions.
  task automatic make_code(input int p);
    bit g1[1:10], g2[1:10];
    bit f1, f2;
    for (int j = 1; j <= 10; j++) begin g1[j] = 1'b1; g2[j] = 1'b1; end
    for (int i = 0; i < L; i++) begin
      code[i] = g1[10] ^ g2[T1[p]] ^ g2[T2[p]];
      f1 = g1[3] ^ g1[10];
      f2 = g2[2] ^ g2[3] ^ g2[6] ^ g2[8] ^ g2[9] ^ g2[10];
      for (int j = 10; j > 1; j--) begin g1[j] = g1[j-1]; g2[j] = g2[j-1]; end
      g1[1] = f1;
      g2[1] = f2;
    end
  endtask

  task automatic build_sig(input int sp, input int d, input int noise);
    make_code(sp);
    sig = new[NP * 1024 + 4096];
    foreach (sig[i]) sig[i] = code[(d + i) % L] ^ bit'($urandom_range(99) < noise);
  endtask

  // Dwell p uses stream samples p*1024 .. p*1024+1022; the sample between dwells is the slip.
  task automatic model(input int p, output exp_t e);
    int acc, mag, best, bp;
    if (p < 1 || p > 32) begin e = '{0, 1, 0, 0}; return; end
    make_code(p);
    best = 0; bp = 0;
    for (int ph = 0; ph < NP; ph++) begin
      acc = 0;
      for (int k = 0; k < L; k++) acc += (sig[ph * 1024 + k] == code[k]) ? 1 : -1;
      mag = (acc < 0) ? -acc : acc;
      if (mag >= TH) begin e = '{1, 0, ph, mag}; return; end
      if (mag > best) begin best = mag; bp = ph; end
    end
    e = '{0, 1, bp, best};
  endtask

  always @(negedge clk) begin
    if (rst_n && done) begin
      ndone++;
      t_done = $time;
      if (sbq.size() == 0) chk("spurious_done", int'(done), 0);
      else begin
        me = sbq.pop_front();
        chk("lock", int'(lock), me.lk);
        chk("fail", int'(fail), me.fl);
        chk("code_phase", int'(code_phase), me.ph);
        chk("corr_peak", int'(corr_peak), me.pk);
        chk("busy_at_done", int'(busy), 1);
      end
    end
  end

  // mode 0: every cycle, 1: every 3rd cycle, 2: random gaps. abort_at>0 stops feeding early.
  task automatic run(input int p, input int sp, input int d, input int noise,
                     input int mode, input int lat, input int abort_at);
    exp_t e;
    int   n0, idx, cyc;
    bit   v;
    time  t0;
    build_sig(sp, d, noise);
    if (abort_at == 0) begin model(p, e); sbq.push_back(e); end
    @(posedge clk); #1;
    start = 1'b1; prn = 6'(p); in_valid = 1'b0;
    @(posedge clk); t0 = $time; #1;
    start = 1'b0;
    n0 = ndone; idx = 0; cyc = 0;
    while (ndone == n0 && cyc < BUDGET && (abort_at == 0 || cyc < abort_at)) begin
      case (mode)
        0:       v = 1'b1;
        1:       v = (cyc % 3 == 0);
        default: v = ($urandom_range(3) != 0);
      endcase
      in_valid  = v;
      in_sample = (v && idx < sig.size()) ? sig[idx] : 1'b0;
      if (v) idx++;
      @(posedge clk); #1;
      cyc++;
    end
    in_valid = 1'b0;
    if (abort_at == 0) begin
      if (ndone == n0) begin
        total++; bad++;
        $display("FAIL timeout prn=%0d: no done after %0d cycles", p, cyc);
      end else begin
        if (lat > 0) chk("done_latency", int'((t_done - t0 + 5) / 10), lat);
        @(negedge clk);
        chk("busy_after_done", int'(busy), 0);
      end
    end
  endtask

  initial begin
    int nb;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_lock", int'(lock), 0);
    chk("rst_fail", int'(fail), 0);
    chk("rst_code_phase", int'(code_phase), 0);
    chk("rst_corr_peak", int'(corr_peak), 0);
    rst_n = 1'b1;

    run(1, 1, 0, 0, 0, 1025, 0);        // aligned, noiseless
    run(1, 1, 1020, 0, 2, 0, 0);        // phase 3, random gaps
    run(2, 2, 1022, 0, 1, 0, 0);        // phase 1 via SLIP state
    run(2, 2, 1022, 0, 0, 0, 0);        // phase 1 via sample on EVAL cycle
    run(3, 7, $urandom_range(L - 1), 0, 0, 0, 0); // cross-correlation only: fail
    run(0, 1, 0, 0, 0, 1, 0);
    run(33, 1, 0, 0, 0, 1, 0);
    for (int i = 0; i < 3; i++)
      run($urandom_range(1, 32), 0, 0, 0, 0, 0, 0 + 0 * i + 1 - 1 + 0) ;
    for (int i = 0; i < 3; i++) begin
      int p;
      p = $urandom_range(1, 32);
      run(p, p, (L - $urandom_range(0, 2)) % L, 15, 2, 0, 0);
    end

    // lock at phase 2 first so the held outputs are non-zero, then abort by reset
    run(4, 4, 1021, 0, 0, 0, 0);
    nb = ndone;
    run(1, 1, 0, 0, 0, 0, 400);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_busy", int'(busy), 0);
    chk("abort_done", int'(done), 0);
    chk("abort_lock", int'(lock), 0);
    chk("abort_fail", int'(fail), 0);
    chk("abort_code_phase", int'(code_phase), 0);
    chk("abort_corr_peak", int'(corr_peak), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    chk("no_done_on_abort", ndone, nb);
    run(1, 1, 0, 0, 0, 1025, 0);

    // restart mid-dwell: only the second search may finish
    run(1, 1, 0, 0, 0, 0, 500);
    nb = ndone;
    run(5, 5, 1021, 0, 2, 0, 0);
    chk("single_done_on_restart", ndone, nb + 1);
    chk("scoreboard_drained", sbq.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
